// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard for decode hazard stalls.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en0,
  input  logic [AW-1:0]          wr_addr0,
  input  logic [WIDTH-1:0]       wr_data0,
  input  logic                   wr_en1,
  input  logic [AW-1:0]          wr_addr1,
  input  logic [WIDTH-1:0]       wr_data1,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_dest,
  output logic                   issue_ok,
  output logic [DEPTH-1:0]       busy_vec
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             issue_take;

  assign issue_ok   = ~busy_q[issue_dest];
  assign issue_take = issue_en & issue_ok;
  assign busy_vec   = busy_q;

  // Clears are applied first so that a same-cycle claim leaves the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en0) busy_d[wr_addr0] = 1'b0;
    if (wr_en1) busy_d[wr_addr1] = 1'b0;
    if (issue_take) busy_d[issue_dest] = 1'b1;
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en0) regs_q[wr_addr0] <= wr_data0;
      if (wr_en1) regs_q[wr_addr1] <= wr_data1;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[g*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic hit0, hit1, claim;
    assign hit0  = wr_en0 && (wr_addr0 == addr);
    assign hit1  = wr_en1 && (wr_addr1 == addr);
    assign claim = issue_take && (issue_dest == addr);

    always_comb begin
      if (hit1) begin
        rd_data[g*WIDTH +: WIDTH] = wr_data1;
      end else if (hit0) begin
        rd_data[g*WIDTH +: WIDTH] = wr_data0;
      end else begin
        rd_data[g*WIDTH +: WIDTH] = regs_q[addr];
      end
    end

    // A writeback in flight resolves the hazard unless a new producer claims it now.
    assign rd_busy[g] = ((hit0 || hit1) && !claim) ? 1'b0 : busy_q[addr];
`else
    assign rd_data[g*WIDTH +: WIDTH] = regs_q[addr];
    assign rd_busy[g]                = busy_q[addr];
`endif
  end

endmodule
